dzmcu_mem_ctrl: RTL and testbench

- Memory control unit directly downstream of the dzcpu bus port (address, data out, write enable, read request).
- Decodes the 16-bit GB address map and steers each access to one of four targets: boot ROM, unified external memory (cart ROM/VRAM/ext RAM/WRAM/OAM), internal HRAM, or the IO register block.
- Returns read data to the CPU with fixed one-cycle latency.
- Owns the boot-ROM disable latch (FF50) and the OAM DMA engine (FF46).

---
 rtl/dzmcu_mem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dzmcu_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dzmcu_mem_ctrl.sv
// dzmcu memory control unit: GB address decode, 1-cycle read return,
// boot ROM overlay latch and OAM DMA engine.
module dzmcu_mem_ctrl #(
  parameter int          DMA_LENGTH     = 160,
  parameter int          BOOT_SIZE      = 256,
  parameter logic [7:0]  UNMAPPED_VALUE = 8'hFF
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuWe,
  input  logic        iCpuReadRequest,
  output logic [7:0]  oCpuData,
  output logic [7:0]  oBootAddr,
  input  logic [7:0]  iBootData,
  output logic [15:0] oMemAddr,
  output logic [7:0]  oMemData,
  output logic        oMemWe,
  input  logic [7:0]  iMemData,
  output logic [7:0]  oIoAddr,
  output logic [7:0]  oIoData,
  output logic        oIoWe,
  input  logic [7:0]  iIoData,
  output logic        oBootEnable,
  output logic        oDmaBusy
);

  typedef enum logic [2:0] {
    R_NONE, R_BOOT, R_EXT, R_HRAM, R_IO, R_UNMAP
  } region_t;

  typedef enum logic [1:0] {
    DMA_IDLE, DMA_READ, DMA_WRITE
  } dma_t;

  localparam logic [16:0] BOOT_END = 17'(BOOT_SIZE);
  localparam logic [7:0]  DMA_LAST = 8'(DMA_LENGTH - 1);

  region_t     region;
  region_t     rd_region;
  logic [15:0] ext_addr;
  logic        rd_pending;
  logic [7:0]  hold;
  logic [7:0]  hram_q;
  logic [7:0]  hram [0:126];

  dma_t        dma_state;
  logic [7:0]  dma_cnt;
  logic [15:0] dma_base;
  logic [15:0] src_raw;
  logic [15:0] src_addr;
  logic        ext_write;
  logic        dma_wr;
  logic        rd_take;

  always_comb begin
    region   = R_UNMAP;
    ext_addr = iCpuAddr;
    if (oBootEnable && ({1'b0, iCpuAddr} < BOOT_END))
      region = R_BOOT;
    else if (iCpuAddr < 16'hE000)
      region = R_EXT;
    else if (iCpuAddr < 16'hFE00) begin
      region   = R_EXT;
      ext_addr = iCpuAddr - 16'h2000;
    end else if (iCpuAddr < 16'hFEA0)
      region = R_EXT;
    else if (iCpuAddr < 16'hFF00)
      region = R_UNMAP;
    else if (iCpuAddr < 16'hFF80 || iCpuAddr == 16'hFFFF)
      region = R_IO;
    else
      region = R_HRAM;
  end

  // DMA source follows the same echo folding as CPU accesses
  assign src_raw  = dma_base + {8'h00, dma_cnt};
  assign src_addr = (src_raw >= 16'hE000) ? src_raw - 16'h2000 : src_raw;

  assign dma_wr    = (dma_state == DMA_WRITE);
  assign ext_write = iCpuWe && (region == R_EXT) && !oDmaBusy;
  assign rd_take   = iCpuReadRequest && !iCpuWe;

  always_comb begin
    oMemAddr = ext_addr;
    if (dma_state == DMA_READ)
      oMemAddr = src_addr;
    else if (dma_wr)
      oMemAddr = 16'hFE00 + {8'h00, dma_cnt};
  end

  assign oMemData  = dma_wr ? iMemData : iCpuData;
  assign oMemWe    = !iReset && (dma_wr || ext_write);
  assign oBootAddr = iCpuAddr[7:0];
  assign oIoAddr   = iCpuAddr[7:0];
  assign oIoData   = iCpuData;
  assign oIoWe     = !iReset && iCpuWe && (region == R_IO);

  always_comb begin
    oCpuData = hold;
    if (rd_pending) begin
      case (rd_region)
        R_BOOT:  oCpuData = iBootData;
        R_EXT:   oCpuData = iMemData;
        R_HRAM:  oCpuData = hram_q;
        R_IO:    oCpuData = iIoData;
        default: oCpuData = UNMAPPED_VALUE;
      endcase
    end
  end

  always_ff @(posedge iClock) begin
    if (iCpuWe && region == R_HRAM)
      hram[iCpuAddr[6:0]] <= iCpuData;
    if (rd_take && region == R_HRAM)
      hram_q <= hram[iCpuAddr[6:0]];
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      rd_pending <= 1'b0;
      rd_region  <= R_NONE;
      hold       <= 8'h00;
    end else begin
      hold       <= oCpuData;
      rd_pending <= rd_take;
      if (rd_take) begin
        if (oDmaBusy && region != R_HRAM && region != R_IO)
          rd_region <= R_UNMAP;
        else
          rd_region <= region;
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset)
      oBootEnable <= 1'b1;
    else if (iCpuWe && iCpuAddr == 16'hFF50 && iCpuData != 8'h00)
      oBootEnable <= 1'b0;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      dma_state <= DMA_IDLE;
      dma_cnt   <= 8'h00;
      dma_base  <= 16'h0000;
      oDmaBusy  <= 1'b0;
    end else if (iCpuWe && iCpuAddr == 16'hFF46) begin
      dma_base  <= {iCpuData, 8'h00};
      dma_cnt   <= 8'h00;
      oDmaBusy  <= 1'b1;
      dma_state <= DMA_READ;
    end else begin
      case (dma_state)
        DMA_READ: dma_state <= DMA_WRITE;
        DMA_WRITE: begin
          dma_cnt <= dma_cnt + 8'h01;
          if (dma_cnt == DMA_LAST) begin
            dma_state <= DMA_IDLE;
            oDmaBusy  <= 1'b0;
          end else begin
            dma_state <= DMA_READ;
          end
        end
        default: dma_state <= DMA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dzmcu_mem_ctrl.sv
// Directed bench for dzmcu_mem_ctrl: decode, read latency,
// boot latch, HRAM, echo writes and OAM DMA restart/abort.
module tb_dzmcu_mem_ctrl;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic        iCpuWe;
  logic        iCpuReadRequest;
  logic [7:0]  oCpuData;
  logic [7:0]  oBootAddr;
  logic [7:0]  iBootData;
  logic [15:0] oMemAddr;
  logic [7:0]  oMemData;
  logic        oMemWe;
  logic [7:0]  iMemData = 8'h00;
  logic [7:0]  oIoAddr;
  logic [7:0]  oIoData;
  logic        oIoWe;
  logic [7:0]  iIoData;
  logic        oBootEnable;
  logic        oDmaBusy;

  logic        mem_mode;
  logic [7:0]  mem_const;
  int          vectors = 0;
  int          errors  = 0;
  int          busy_cycles;
  int          late_we;

  dzmcu_mem_ctrl dut (
    .iClock          (iClock),
    .iReset          (iReset),
    .iCpuAddr        (iCpuAddr),
    .iCpuData        (iCpuData),
    .iCpuWe          (iCpuWe),
    .iCpuReadRequest (iCpuReadRequest),
    .oCpuData        (oCpuData),
    .oBootAddr       (oBootAddr),
    .iBootData       (iBootData),
    .oMemAddr        (oMemAddr),
    .oMemData        (oMemData),
    .oMemWe          (oMemWe),
    .iMemData        (iMemData),
    .oIoAddr         (oIoAddr),
    .oIoData         (oIoData),
    .oIoWe           (oIoWe),
    .iIoData         (iIoData),
    .oBootEnable     (oBootEnable),
    .oDmaBusy        (oDmaBusy)
  );

  always #5 iClock = ~iClock;

  // external memory: 1-cycle synchronous read
  always @(posedge iClock)
    iMemData <= mem_mode ? oMemAddr[7:0] : mem_const;

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    iReset = 1'b1;
    iCpuAddr = 16'h0000;
    iCpuData = 8'h00;
    iCpuWe = 1'b0;
    iCpuReadRequest = 1'b0;
    iBootData = 8'h31;
    iIoData = 8'h42;
    mem_mode = 1'b0;
    mem_const = 8'hC3;
    tick();
    tick();
    iReset = 1'b0;

    chk("rst_cpudata", {8'h0, oCpuData}, 16'h0000);
    chk("rst_memwe", {15'h0, oMemWe}, 16'h0000);
    chk("rst_iowe", {15'h0, oIoWe}, 16'h0000);
    chk("rst_boot_en", {15'h0, oBootEnable}, 16'h0001);
    chk("rst_dma_busy", {15'h0, oDmaBusy}, 16'h0000);

    iCpuAddr = 16'h0000;
    iCpuReadRequest = 1'b1;
    #1 chk("boot_addr", {8'h0, oBootAddr}, 16'h0000);
    tick();
    iCpuReadRequest = 1'b0;
    chk("boot_read", {8'h0, oCpuData}, 16'h0031);
    tick();
    chk("read_hold", {8'h0, oCpuData}, 16'h0031);

    iCpuAddr = 16'hFF50;
    iCpuData = 8'h00;
    iCpuWe = 1'b1;
    #1 chk("ff50_fwd_io", {15'h0, oIoWe}, 16'h0001);
    tick();
    chk("ff50_zero", {15'h0, oBootEnable}, 16'h0001);
    iCpuData = 8'h01;
    tick();
    iCpuWe = 1'b0;
    chk("ff50_clear", {15'h0, oBootEnable}, 16'h0000);

    iCpuAddr = 16'h0000;
    iCpuReadRequest = 1'b1;
    tick();
    iCpuReadRequest = 1'b0;
    chk("ext_read_0000", {8'h0, oCpuData}, 16'h00C3);

    iCpuAddr = 16'hFF85;
    iCpuData = 8'h5A;
    iCpuWe = 1'b1;
    tick();
    iCpuWe = 1'b0;
    iCpuReadRequest = 1'b1;
    tick();
    iCpuReadRequest = 1'b0;
    chk("hram_read", {8'h0, oCpuData}, 16'h005A);

    iCpuAddr = 16'hFF86;
    iCpuData = 8'h11;
    iCpuWe = 1'b1;
    iCpuReadRequest = 1'b1;
    tick();
    iCpuWe = 1'b0;
    iCpuReadRequest = 1'b0;
    chk("we_wins", {8'h0, oCpuData}, 16'h005A);
    iCpuReadRequest = 1'b1;
    tick();
    iCpuReadRequest = 1'b0;
    chk("hram_read2", {8'h0, oCpuData}, 16'h0011);

    iCpuAddr = 16'hFEA5;
    iCpuReadRequest = 1'b1;
    tick();
    iCpuReadRequest = 1'b0;
    chk("unmapped_read", {8'h0, oCpuData}, 16'h00FF);
    iCpuWe = 1'b1;
    #1 chk("unmapped_memwe", {15'h0, oMemWe}, 16'h0000);
    chk("unmapped_iowe", {15'h0, oIoWe}, 16'h0000);
    tick();
    iCpuWe = 1'b0;

    iCpuAddr = 16'hFF40;
    iCpuReadRequest = 1'b1;
    tick();
    iCpuReadRequest = 1'b0;
    chk("io_read", {8'h0, oCpuData}, 16'h0042);

    iCpuAddr = 16'hE010;
    iCpuData = 8'h77;
    iCpuWe = 1'b1;
    #1 chk("echo_we", {15'h0, oMemWe}, 16'h0001);
    chk("echo_addr", oMemAddr, 16'hC010);
    chk("echo_data", {8'h0, oMemData}, 16'h0077);
    tick();
    iCpuWe = 1'b0;
    #1 chk("echo_we_pulse", {15'h0, oMemWe}, 16'h0000);

    mem_mode = 1'b1;
    iCpuAddr = 16'hFF46;
    iCpuData = 8'hC1;
    iCpuWe = 1'b1;
    tick();
    iCpuWe = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 160; k++) begin
      chk("dma_rd_we", {15'h0, oMemWe}, 16'h0000);
      chk("dma_rd_addr", oMemAddr, 16'(16'hC100 + k));
      if (k == 20) begin
        iCpuAddr = 16'hC000;
        iCpuReadRequest = 1'b1;
      end
      if (k == 40) begin
        iCpuAddr = 16'hFF85;
        iCpuReadRequest = 1'b1;
      end
      if (oDmaBusy) busy_cycles++;
      tick();
      iCpuReadRequest = 1'b0;
      chk("dma_wr_we", {15'h0, oMemWe}, 16'h0001);
      chk("dma_wr_addr", oMemAddr, 16'(16'hFE00 + k));
      chk("dma_wr_data", {8'h0, oMemData}, 16'(k));
      if (k == 20) chk("dma_blocked_rd", {8'h0, oCpuData}, 16'h00FF);
      if (k == 40) chk("dma_hram_rd", {8'h0, oCpuData}, 16'h005A);
      if (oDmaBusy) busy_cycles++;
      tick();
    end
    chk("dma_done_busy", {15'h0, oDmaBusy}, 16'h0000);
    chk("dma_done_we", {15'h0, oMemWe}, 16'h0000);
    chk("dma_busy_len", 16'(busy_cycles), 16'd320);

    iCpuAddr = 16'hFF46;
    iCpuData = 8'hC1;
    iCpuWe = 1'b1;
    tick();
    iCpuWe = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      tick();
    end
    chk("rs_pre_addr", oMemAddr, 16'hC132);
    iCpuData = 8'hD0;
    iCpuWe = 1'b1;
    #1 chk("rs_fwd_io", {15'h0, oIoWe}, 16'h0001);
    tick();
    iCpuWe = 1'b0;
    for (int k = 0; k < 80; k++) begin
      chk("rs_rd_addr", oMemAddr, 16'(16'hD000 + k));
      tick();
      chk("rs_wr_addr", oMemAddr, 16'(16'hFE00 + k));
      chk("rs_wr_we", {15'h0, oMemWe}, 16'h0001);
      tick();
    end
    chk("rs_cnt80_addr", oMemAddr, 16'hD050);
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    chk("abort_busy", {15'h0, oDmaBusy}, 16'h0000);
    chk("abort_boot_en", {15'h0, oBootEnable}, 16'h0001);
    late_we = 0;
    for (int k = 0; k < 10; k++) begin
      if (oMemWe) late_we++;
      tick();
    end
    chk("abort_no_we", 16'(late_we), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
